mem_initiator: RTL and testbench
================================

Name: mem_initiator

Overview:
- Synthesizable initiator (requester) end of the team's memory valid/ready request/response interface; drives the same protocol the memory and cache models respond to.
- Accepts read/write commands from a client, issues them to memory, and tracks outstanding reads in order.
- Returns read data with its address, flags spurious responses and response timeouts.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_OUT, 4, max outstanding reads (power of 2, >=2)
TIMEOUT, 256, cycles without a response while reads are outstanding before err_timeout

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  client command valid
cmd_ready  out  1  command accepted when valid&&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  command address
cmd_wdata  in  DATA_W  write data
req_valid  out  1  memory request valid
req_ready  in  1  memory accepts request
req_write  out  1  request type
req_addr  out  ADDR_W  request address
req_wdata  out  DATA_W  request write data
rsp_valid  in  1  read response valid (no backpressure; reads only, writes are posted)
rsp_rdata  in  DATA_W  read response data
rd_valid  out  1  read result pulse
rd_addr  out  ADDR_W  address of returned read
rd_data  out  DATA_W  returned data
out_cnt  out  $clog2(MAX_OUT)+1  outstanding reads
busy  out  1  state!=IDLE or out_cnt!=0
err_clr  in  1  clears sticky errors
err_spurious  out  1  sticky: rsp_valid with out_cnt==0
err_timeout  out  1  sticky: response timeout

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, all outputs 0, out_cnt=0, pending FIFO emptied, timeout counter=0, errors cleared. Applies mid-transaction: in-flight request dropped, pending reads forgotten; responses arriving after reset are spurious.
- FSM IDLE/REQ.
  - IDLE: cmd_ready = (out_cnt < MAX_OUT), independent of cmd_write. On cmd handshake, latch write/addr/wdata into req regs -> REQ.
  - REQ: req_valid=1; req_* stable until req_ready. On req handshake -> IDLE; if read, push req_addr to pending FIFO and increment out_cnt.
- cmd_ready=0 in REQ; max throughput one command per 2 cycles.
- Pending FIFO depth MAX_OUT, in-order; responses return in request order.
- Response: rsp_valid with out_cnt>0 -> pop head. Next cycle: rd_valid=1, rd_addr=popped addr, rd_data=rsp_rdata (1-cycle latency). rd_valid is 0 otherwise; rd_addr/rd_data hold their last value.
- rsp_valid with out_cnt==0 -> set err_spurious; no rd_valid; counters unchanged.
- Same-cycle read push and pop: out_cnt unchanged; FIFO pointers both advance. Push while full is impossible, since cmd_ready gates on out_cnt.
- out_cnt reaches MAX_OUT -> cmd_ready=0 until a response pops. A write command also stalls at MAX_OUT.
- Timeout counter:
  - Cleared when out_cnt==0 or on any valid response.
  - Otherwise increments, saturating at TIMEOUT.
  - Reaching TIMEOUT sets err_timeout. Outstanding reads stay pending; a later response still completes normally.
- err_clr clears both errors that cycle. An error event in the same cycle as err_clr wins (flag set).
- busy is combinational from state and out_cnt.

Test Plan:
- Write addr 0x10 data 0xA5A5, req_ready=1 -> req_valid for 1 cycle with req_write=1, req_addr=0x10, req_wdata=0xA5A5; out_cnt stays 0; no rd_valid.
- Reads 0x100, 0x104, 0x108; memory returns 0x11, 0x22, 0x33 -> rd_valid pulses with (0x100,0x11), (0x104,0x22), (0x108,0x33), each 1 cycle after rsp_valid; out_cnt ends 0.
- Hold req_ready=0 for 5 cycles during a read -> req_* stable, cmd_ready=0 for all 5 cycles; handshake on cycle 6, then out_cnt=1.
- Issue 4 reads, no responses -> out_cnt=4, cmd_ready=0 with a 5th (write) pending. One response -> cmd_ready=1 next cycle. Response in same cycle as a new read's req handshake -> out_cnt unchanged.
- rsp_valid with out_cnt=0 -> err_spurious=1, no rd_valid. Then one read with no response for 256 cycles -> err_timeout=1. err_clr -> both 0. Late response -> normal rd_valid.
- rst_n=0 for 1 cycle with 2 reads outstanding and req_valid=1 -> all outputs 0, out_cnt=0. Late response afterwards -> err_spurious=1.

Source files
------------

// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - memory request initiator with in-order read tracking
module mem_initiator #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [ADDR_W-1:0]          cmd_addr,
    input  logic [DATA_W-1:0]          cmd_wdata,
    output logic                       req_valid,
    input  logic                       req_ready,
    output logic                       req_write,
    output logic [ADDR_W-1:0]          req_addr,
    output logic [DATA_W-1:0]          req_wdata,
    input  logic                       rsp_valid,
    input  logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rd_valid,
    output logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(MAX_OUT):0]   out_cnt,
    output logic                       busy,
    input  logic                       err_clr,
    output logic                       err_spurious,
    output logic                       err_timeout
);
    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pend_addr [MAX_OUT];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [TW-1:0]       tcnt;

    logic                cmd_fire;
    logic                req_fire;
    logic                push;
    logic                pop;
    logic                spur;
    logic                tick_en;
    logic                to_event;
    logic [CW-1:0]       out_cnt_nxt;
    state_t              state_nxt;

    assign cmd_fire    = cmd_valid && cmd_ready;
    assign req_fire    = (state == REQ) && req_ready;
    assign push        = req_fire && !req_write;
    assign pop         = rsp_valid && (out_cnt != '0);
    assign spur        = rsp_valid && (out_cnt == '0);
    assign out_cnt_nxt = out_cnt + CW'(push) - CW'(pop);
    assign state_nxt   = (state == IDLE) ? (cmd_fire ? REQ : IDLE)
                                         : (req_fire ? IDLE : REQ);
    assign tick_en     = (out_cnt != '0) && !rsp_valid;
    assign to_event    = tick_en && (tcnt == TW'(TIMEOUT - 1));
    assign req_valid   = (state == REQ);
    assign busy        = (state != IDLE) || (out_cnt != '0);

    // Command/request FSM; cmd_ready is registered from the next-cycle state and count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == IDLE) && (out_cnt_nxt < CW'(MAX_OUT));
            if (cmd_fire) begin
                req_write <= cmd_write;
                req_addr  <= cmd_addr;
                req_wdata <= cmd_wdata;
            end
        end
    end

    // Pending-read address storage; contents are only meaningful between pointers
    always_ff @(posedge clk) begin
        if (push) pend_addr[wr_ptr] <= req_addr;
    end

    // Pending-read pointers, outstanding count and read result return
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            out_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            rd_data  <= '0;
        end else begin
            out_cnt  <= out_cnt_nxt;
            rd_valid <= pop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_addr <= pend_addr[rd_ptr];
                rd_data <= rsp_rdata;
            end
        end
    end

    // Response timeout counter and sticky error flags; a new event beats err_clr
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt         <= '0;
            err_spurious <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (!tick_en)
                tcnt <= '0;
            else if (tcnt != TW'(TIMEOUT))
                tcnt <= tcnt + 1'b1;
            err_spurious <= (err_spurious && !err_clr) || spur;
            err_timeout  <= (err_timeout && !err_clr) || to_event;
        end
    end
endmodule

// File: tb/tb_mem_initiator.sv
// tb/tb_mem_initiator.sv - directed self-checking bench for mem_initiator
module tb_mem_initiator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rd_valid;
    logic [31:0] rd_addr, rd_data;
    logic [2:0]  out_cnt;
    logic        busy, err_clr, err_spurious, err_timeout;

    int errors = 0;
    int checks = 0;

    mem_initiator #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(4), .TIMEOUT(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_cnt(out_cnt), .busy(busy), .err_clr(err_clr),
        .err_spurious(err_spurious), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        if (!cmd_ready) chk("wait_cmd_ready", {63'b0, cmd_ready}, 64'd1);
    endtask

    // Present a command until accepted; leaves the DUT in REQ
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        wait_ready();
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Full read issue with req_ready high: command cycle plus request cycle
    task automatic issue_read(input logic [31:0] a);
        send_cmd(1'b0, a, 32'h0);
        tick();
    endtask

    task automatic respond(input logic [31:0] d, input logic [31:0] exp_addr, input string tag);
        rsp_valid = 1'b1; rsp_rdata = d;
        tick();
        rsp_valid = 1'b0;
        chk({tag, "_rd_valid"}, {63'b0, rd_valid}, 64'd1);
        chk({tag, "_rd_addr"}, {32'b0, rd_addr}, {32'b0, exp_addr});
        chk({tag, "_rd_data"}, {32'b0, rd_data}, {32'b0, d});
    endtask

    logic [31:0] rd_addrs [3];
    logic [31:0] rd_datas [3];

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        req_ready = 1'b1; rsp_valid = 1'b0; rsp_rdata = '0; err_clr = 1'b0;
        tick(); tick();
        chk("rst_cmd_ready", {63'b0, cmd_ready}, 64'd0);
        chk("rst_req_valid", {63'b0, req_valid}, 64'd0);
        chk("rst_out_cnt", {61'b0, out_cnt}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_errs", {62'b0, err_spurious, err_timeout}, 64'd0);
        chk("rst_rd_valid", {63'b0, rd_valid}, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_cmd_ready", {63'b0, cmd_ready}, 64'd1);

        // Posted write
        send_cmd(1'b1, 32'h10, 32'hA5A5);
        chk("wr_req_valid", {63'b0, req_valid}, 64'd1);
        chk("wr_req_write", {63'b0, req_write}, 64'd1);
        chk("wr_req_addr", {32'b0, req_addr}, 64'h10);
        chk("wr_req_wdata", {32'b0, req_wdata}, 64'hA5A5);
        chk("wr_cmd_ready_req", {63'b0, cmd_ready}, 64'd0);
        tick();
        chk("wr_req_valid_done", {63'b0, req_valid}, 64'd0);
        chk("wr_out_cnt", {61'b0, out_cnt}, 64'd0);
        chk("wr_rd_valid", {63'b0, rd_valid}, 64'd0);

        // Three in-order reads
        rd_addrs[0] = 32'h100; rd_addrs[1] = 32'h104; rd_addrs[2] = 32'h108;
        rd_datas[0] = 32'h11;  rd_datas[1] = 32'h22;  rd_datas[2] = 32'h33;
        for (int i = 0; i < 3; i++) issue_read(rd_addrs[i]);
        chk("rd3_out_cnt", {61'b0, out_cnt}, 64'd3);
        for (int i = 0; i < 3; i++) respond(rd_datas[i], rd_addrs[i], "rd3");
        chk("rd3_out_cnt_end", {61'b0, out_cnt}, 64'd0);
        tick();
        chk("rd3_rd_valid_off", {63'b0, rd_valid}, 64'd0);
        chk("rd3_rd_addr_hold", {32'b0, rd_addr}, 64'h108);

        // Request stalled by memory for 5 cycles
        req_ready = 1'b0;
        send_cmd(1'b0, 32'h200, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_req_valid", {63'b0, req_valid}, 64'd1);
            chk("stall_req_addr", {32'b0, req_addr}, 64'h200);
            chk("stall_req_write", {63'b0, req_write}, 64'd0);
            chk("stall_cmd_ready", {63'b0, cmd_ready}, 64'd0);
            if (i < 4) tick();
        end
        req_ready = 1'b1;
        tick();
        chk("stall_out_cnt", {61'b0, out_cnt}, 64'd1);
        chk("stall_req_valid_done", {63'b0, req_valid}, 64'd0);
        respond(32'h55, 32'h200, "stall");

        // Fill to MAX_OUT, write stalls until a response pops
        for (int i = 0; i < 4; i++) issue_read(32'h300 + 32'(4 * i));
        chk("full_out_cnt", {61'b0, out_cnt}, 64'd4);
        chk("full_cmd_ready", {63'b0, cmd_ready}, 64'd0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h400; cmd_wdata = 32'hBEEF;
        tick();
        chk("full_wr_stalled_ready", {63'b0, cmd_ready}, 64'd0);
        chk("full_wr_stalled_req", {63'b0, req_valid}, 64'd0);
        respond(32'hAA, 32'h300, "full");
        chk("full_ready_after_pop", {63'b0, cmd_ready}, 64'd1);
        chk("full_out_cnt_3", {61'b0, out_cnt}, 64'd3);
        tick();
        cmd_valid = 1'b0;
        chk("full_wr_req_write", {63'b0, req_write}, 64'd1);
        chk("full_wr_req_addr", {32'b0, req_addr}, 64'h400);
        tick();
        chk("full_wr_out_cnt", {61'b0, out_cnt}, 64'd3);
        // Read request handshake in the same cycle as a response
        send_cmd(1'b0, 32'h500, 32'h0);
        respond(32'hBB, 32'h304, "pushpop");
        chk("pushpop_out_cnt", {61'b0, out_cnt}, 64'd3);
        respond(32'hC1, 32'h308, "drain");
        respond(32'hC2, 32'h30C, "drain");
        respond(32'hC3, 32'h500, "drain");
        chk("drain_out_cnt", {61'b0, out_cnt}, 64'd0);

        // Spurious response, then timeout, clear, late response
        rsp_valid = 1'b1; rsp_rdata = 32'hDEAD;
        tick();
        rsp_valid = 1'b0;
        chk("spur_flag", {63'b0, err_spurious}, 64'd1);
        chk("spur_no_rd_valid", {63'b0, rd_valid}, 64'd0);
        chk("spur_out_cnt", {61'b0, out_cnt}, 64'd0);
        issue_read(32'h600);
        repeat (255) tick();
        chk("to_not_yet", {63'b0, err_timeout}, 64'd0);
        tick();
        chk("to_flag", {63'b0, err_timeout}, 64'd1);
        chk("to_out_cnt", {61'b0, out_cnt}, 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_spur", {63'b0, err_spurious}, 64'd0);
        chk("clr_to", {63'b0, err_timeout}, 64'd0);
        respond(32'h66, 32'h600, "late");
        chk("late_out_cnt", {61'b0, out_cnt}, 64'd0);

        // Reset mid-transaction
        issue_read(32'h700);
        issue_read(32'h704);
        req_ready = 1'b0;
        send_cmd(1'b0, 32'h708, 32'h0);
        chk("mid_req_valid", {63'b0, req_valid}, 64'd1);
        chk("mid_out_cnt", {61'b0, out_cnt}, 64'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_ready = 1'b1;
        chk("mid_rst_req_valid", {63'b0, req_valid}, 64'd0);
        chk("mid_rst_out_cnt", {61'b0, out_cnt}, 64'd0);
        chk("mid_rst_cmd_ready", {63'b0, cmd_ready}, 64'd0);
        chk("mid_rst_busy", {63'b0, busy}, 64'd0);
        chk("mid_rst_rd_addr", {32'b0, rd_addr}, 64'd0);
        rsp_valid = 1'b1; rsp_rdata = 32'h77;
        tick();
        rsp_valid = 1'b0;
        chk("post_rst_spur", {63'b0, err_spurious}, 64'd1);
        chk("post_rst_no_rd", {63'b0, rd_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
